stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk_base cycles per 10 ms count tick (100 Hz at 100 MHz).
REQ-002 Parameter DEB_CYCLES, default 500000, consecutive stable-high cycles required to accept a button press.
REQ-003 Parameter CNT_W, default 20, width of the prescaler and debounce counters; SHALL hold TICK_DIV-1 and DEB_CYCLES.
REQ-004 clk_base  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_start_stop  input  1  raw start/stop button, active-high.
REQ-007 btn_lap  input  1  raw lap button, active-high.
REQ-008 btn_clear  input  1  raw clear button, active-high.
REQ-009 disp_bcd  output  24  display value {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, 4-bit BCD each.
REQ-010 running  output  1  high in RUN and LAP states.
REQ-011 lap_active  output  1  high in LAP state (display frozen).
REQ-012 overflow  output  1  sticky; set on saturation at 59:59.99.
REQ-013 tick  output  1  one-cycle pulse per count increment.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: counter increments while synced input is high, clears to 0 when low, saturates at DEB_CYCLES.
REQ-015 A press event SHALL be a one-cycle pulse in the cycle the debounce counter first reaches DEB_CYCLES; holding the button SHALL produce no further events until release.
REQ-016 States SHALL be IDLE, RUN, PAUSE, LAP; state register updates on the edge after the event pulse.
REQ-017 IDLE: start_stop -> RUN; lap and clear ignored.
REQ-018 RUN: start_stop -> PAUSE; lap -> LAP, latching the live count into the display register in the same edge.
REQ-019 LAP: lap -> RUN (display live again); start_stop -> PAUSE (display live, showing stopped count).
REQ-020 PAUSE: start_stop -> RUN; clear -> IDLE with live count, prescaler, overflow zeroed; lap ignored.
REQ-021 Simultaneous events SHALL be prioritized start_stop > lap > clear; lower-priority events in that cycle are discarded.
REQ-022 clear SHALL be ignored in RUN and LAP.
REQ-023 Prescaler SHALL count only in RUN and LAP; at TICK_DIV-1 it wraps to 0 and asserts tick for that cycle.
REQ-024 Prescaler SHALL hold its value in PAUSE (no lost fraction on resume) and be 0 in IDLE.
REQ-025 On tick the live count SHALL increment as BCD: cs_o 9->0 carries to cs_t; cs_t 9->0 to sec_o; sec_o 9->0 to sec_t; sec_t 5->0 to min_o; min_o 9->0 to min_t; min_t max 5.
REQ-026 At 59:59.99 a tick SHALL NOT wrap: count holds, overflow sets, state goes to PAUSE on the same edge.
REQ-027 In RUN/LAP with overflow=1, no increments SHALL occur; only clear from PAUSE resets overflow.
REQ-028 disp_bcd SHALL show the live count except in LAP, where it shows the latched value.
REQ-029 No BCD digit SHALL ever hold a value above 9 (tens-of-seconds/minutes above 5).

Reset
REQ-030 When reset is high at a clk_base edge: state IDLE, count, latch, prescaler, debounce counters, synchronizers zero; disp_bcd=0, running=0, lap_active=0, overflow=0, tick=0.
REQ-031 Reset SHALL take priority over all events and apply mid-count and mid-debounce identically.

Verification (TICK_DIV=4, DEB_CYCLES=2)
REQ-032 Press start_stop, hold 10 cycles -> single event, running=1; 40 cycles later disp_bcd=24'h000010 and exactly 10 tick pulses.
REQ-033 Start, run to 00:00.05, press lap -> lap_active=1, disp_bcd stays 24'h000005 while counting continues; lap again -> display jumps to live value.
REQ-034 Glitch btn_clear high 1 cycle in PAUSE -> no event, state unchanged; hold 3 cycles -> IDLE, disp_bcd=0.
REQ-035 Preload count 00:59.99 via run, one tick -> 24'h010000; run to 59:59.99, next tick -> value held, overflow=1, running=0.
REQ-036 start_stop and lap events in same cycle while RUN -> PAUSE, lap_active=0.
REQ-037 Assert reset mid-RUN at 00:03.47 -> next cycle all outputs 0, state IDLE; press start resumes from 00:00.00.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Start/stop/lap/clear stopwatch controller counting in 10 ms steps up to
//   59:59.99. Each raw button is synchronized and debounced into a one-cycle
//   press event; a four-state FSM (IDLE, RUN, PAUSE, LAP) interprets the
//   events and drives a BCD time counter fed by a prescaler.
//
// Ports
//   clk_base        in   system clock, all state on its rising edge
//   reset           in   synchronous, active-high reset
//   btn_start_stop  in   raw start/stop button, active-high
//   btn_lap         in   raw lap button, active-high
//   btn_clear       in   raw clear button, active-high
//   disp_bcd        out  {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, 4-bit BCD each
//   running         out  high in RUN and LAP
//   lap_active      out  high in LAP (display frozen on the latched value)
//   overflow        out  sticky saturation flag at 59:59.99
//   tick            out  one-cycle pulse per count increment
//   fsm_state       out  current FSM state (IDLE=0, RUN=1, PAUSE=2, LAP=3)
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 1000000,
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic        clk_base,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow,
    output logic        tick,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] DEB_PRE   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [23:0]      COUNT_MAX = 24'h595999;

    // Button index: 0 = start_stop, 1 = lap, 2 = clear
    logic [2:0]       btn_raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [CNT_W-1:0] deb_cnt [3];
    logic [2:0]       ev;

    assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

    // The event flag is registered alongside the counter so it is high exactly
    // in the cycle the counter first holds DEB_MAX; saturation keeps it low
    // for the rest of the hold.
    always_ff @(posedge clk_base) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            ev    <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (!sync2[i]) begin
                    deb_cnt[i] <= '0;
                    ev[i]      <= 1'b0;
                end else begin
                    if (deb_cnt[i] != DEB_MAX) deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                    ev[i] <= (deb_cnt[i] == DEB_PRE);
                end
            end
        end
    end

    state_t           state_q, state_d;
    logic [23:0]      count_q, count_d;
    logic [23:0]      latch_q, latch_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             ovf_q, ovf_d;
    logic             active;
    logic             tick_c;
    logic             at_max;

    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        r = v;
        if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) r[7:4] = v[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
                else begin
                    r[11:8] = 4'd0;
                    if (v[15:12] != 4'd5) r[15:12] = v[15:12] + 4'd1;
                    else begin
                        r[15:12] = 4'd0;
                        if (v[19:16] != 4'd9) r[19:16] = v[19:16] + 4'd1;
                        else begin
                            r[19:16] = 4'd0;
                            r[23:20] = v[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    assign active = (state_q == RUN) || (state_q == LAP);
    assign tick_c = active && !ovf_q && (presc_q == TICK_LAST);
    assign at_max = (count_q == COUNT_MAX);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        latch_d = latch_q;
        presc_d = presc_q;
        ovf_d   = ovf_q;

        // Once saturated the prescaler freezes too, so no ticks are emitted.
        if (tick_c) begin
            presc_d = '0;
            if (at_max) ovf_d = 1'b1;
            else        count_d = bcd_inc(count_q);
        end else if (active && !ovf_q) begin
            presc_d = presc_q + CNT_ONE;
        end

        // Priority start_stop > lap > clear falls out of the if/else order.
        case (state_q)
            IDLE: begin
                if (ev[0]) state_d = RUN;
            end
            RUN: begin
                if (ev[0]) state_d = PAUSE;
                else if (ev[1]) begin
                    state_d = LAP;
                    latch_d = count_q;
                end
            end
            LAP: begin
                if (ev[0])      state_d = PAUSE;
                else if (ev[1]) state_d = RUN;
            end
            PAUSE: begin
                if (ev[0]) state_d = RUN;
                else if (ev[2]) begin
                    state_d = IDLE;
                    count_d = '0;
                    presc_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Saturation stops the watch regardless of any button event.
        if (tick_c && at_max) state_d = PAUSE;
    end

    always_ff @(posedge clk_base) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            latch_q <= '0;
            presc_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            latch_q <= latch_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign disp_bcd   = (state_q == LAP) ? latch_q : count_q;
    assign running    = active;
    assign lap_active = (state_q == LAP);
    assign overflow   = ovf_q;
    assign tick       = tick_c;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_LAP   = 2'd3;

    logic        clk_base = 1'b0;
    logic        reset = 1'b1;
    logic        btn_start_stop = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clear = 1'b0;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;
    logic        tick;
    logic [1:0]  fsm_state;

    int checks = 0;
    int fails = 0;
    int tick_cnt = 0;

    stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYCLES(2), .CNT_W(20)) dut (
        .clk_base(clk_base), .reset(reset), .btn_start_stop(btn_start_stop),
        .btn_lap(btn_lap), .btn_clear(btn_clear), .disp_bcd(disp_bcd),
        .running(running), .lap_active(lap_active), .overflow(overflow),
        .tick(tick), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk_base = ~clk_base;

    always @(negedge clk_base) if (tick === 1'b1) tick_cnt++;

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk_base);
    endtask

    task automatic do_reset();
        step(1);
        reset = 1'b1;
        btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic press_btn(input int which, input int hold);
        case (which)
            0: btn_start_stop = 1'b1;
            1: btn_lap = 1'b1;
            default: btn_clear = 1'b1;
        endcase
        step(hold);
        btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        step(1);
        reset = 1'b1;
        step(2);
        checks++; if (disp_bcd !== 24'h0) begin fails++; $display("FAIL reset_disp: got %h expected 000000", disp_bcd); end
        checks++; if ({running, lap_active, overflow, tick} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {running, lap_active, overflow, tick}); end
        checks++; if (fsm_state !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, S_IDLE); end
        reset = 1'b0;
        // reset landing on the edge that would have produced the press event
        btn_start_stop = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        btn_start_stop = 1'b0;
        step(6);
        checks++; if (fsm_state !== S_IDLE) begin fails++; $display("FAIL reset_mid_debounce: got %0d expected %0d", fsm_state, S_IDLE); end
    endtask

    task automatic test_ignored_idle();
        do_reset();
        press_btn(1, 3);
        press_btn(2, 3);
        step(3);
        checks++; if (fsm_state !== S_IDLE || running !== 1'b0) begin fails++; $display("FAIL idle_ignore: got state %0d running %b expected 0 0", fsm_state, running); end
    endtask

    task automatic test_start_count();
        int rs;
        int t0;
        do_reset();
        rs = -1;
        t0 = 0;
        btn_start_stop = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            step(1);
            if (i == 10) btn_start_stop = 1'b0;
            if (rs < 0 && running === 1'b1) begin rs = i; t0 = tick_cnt; end
            if (rs >= 0 && i == rs + 40) break;
        end
        checks++; if (rs != 5) begin fails++; $display("FAIL start_latency: got %0d expected 5", rs); end
        checks++; if (disp_bcd !== 24'h000010) begin fails++; $display("FAIL count_40: got %h expected 000010", disp_bcd); end
        checks++; if (tick_cnt - t0 != 10) begin fails++; $display("FAIL tick_pulses: got %0d expected 10", tick_cnt - t0); end
        checks++; if (running !== 1'b1) begin fails++; $display("FAIL single_event: got running %b expected 1", running); end
        press_btn(2, 3);
        step(2);
        checks++; if (fsm_state !== S_RUN) begin fails++; $display("FAIL clear_in_run: got %0d expected %0d", fsm_state, S_RUN); end
    endtask

    task automatic test_lap();
        do_reset();
        press_btn(0, 3);
        step(19);
        press_btn(1, 3);
        step(2);
        checks++; if (lap_active !== 1'b1) begin fails++; $display("FAIL lap_enter: got %b expected 1", lap_active); end
        checks++; if (disp_bcd !== 24'h000005) begin fails++; $display("FAIL lap_latch: got %h expected 000005", disp_bcd); end
        step(13);
        checks++; if (disp_bcd !== 24'h000005 || running !== 1'b1) begin fails++; $display("FAIL lap_frozen: got %h run %b expected 000005 1", disp_bcd, running); end
        press_btn(1, 3);
        step(2);
        checks++; if (lap_active !== 1'b0 || disp_bcd !== 24'h000010) begin fails++; $display("FAIL lap_exit: got lap %b disp %h expected 0 000010", lap_active, disp_bcd); end
    endtask

    task automatic test_pause_clear();
        press_btn(0, 3);
        step(2);
        checks++; if (fsm_state !== S_PAUSE || disp_bcd !== 24'h000011) begin fails++; $display("FAIL pause: got state %0d disp %h expected 2 000011", fsm_state, disp_bcd); end
        press_btn(1, 3);
        step(2);
        checks++; if (fsm_state !== S_PAUSE || disp_bcd !== 24'h000011) begin fails++; $display("FAIL lap_in_pause: got state %0d disp %h expected 2 000011", fsm_state, disp_bcd); end
        btn_clear = 1'b1;
        step(1);
        btn_clear = 1'b0;
        step(6);
        checks++; if (fsm_state !== S_PAUSE || disp_bcd !== 24'h000011) begin fails++; $display("FAIL clear_glitch: got state %0d disp %h expected 2 000011", fsm_state, disp_bcd); end
        press_btn(2, 3);
        step(2);
        checks++; if (fsm_state !== S_IDLE || disp_bcd !== 24'h0) begin fails++; $display("FAIL clear: got state %0d disp %h expected 0 000000", fsm_state, disp_bcd); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        press_btn(0, 3);
        step(2);
        checks++; if (running !== 1'b1) begin fails++; $display("FAIL b2b_run: got %b expected 1", running); end
        btn_start_stop = 1'b1;
        btn_lap = 1'b1;
        step(3);
        btn_start_stop = 1'b0;
        btn_lap = 1'b0;
        step(2);
        checks++; if (fsm_state !== S_PAUSE || lap_active !== 1'b0) begin fails++; $display("FAIL b2b_prio: got state %0d lap %b expected 2 0", fsm_state, lap_active); end
        step(8);
        checks++; if (fsm_state !== S_PAUSE) begin fails++; $display("FAIL b2b_stable: got %0d expected 2", fsm_state); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        press_btn(0, 3);
        step(1390);
        checks++; if (disp_bcd !== 24'h000347 || running !== 1'b1) begin fails++; $display("FAIL pre_reset: got %h run %b expected 000347 1", disp_bcd, running); end
        reset = 1'b1;
        step(1);
        checks++; if (disp_bcd !== 24'h0 || {running, lap_active, overflow, tick} !== 4'b0 || fsm_state !== S_IDLE) begin fails++; $display("FAIL mid_reset: got %h flags %b state %0d expected all 0", disp_bcd, {running, lap_active, overflow, tick}, fsm_state); end
        reset = 1'b0;
        press_btn(0, 3);
        step(2);
        checks++; if (running !== 1'b1 || disp_bcd !== 24'h0) begin fails++; $display("FAIL restart: got run %b disp %h expected 1 000000", running, disp_bcd); end
        step(4);
        checks++; if (disp_bcd !== 24'h000001) begin fails++; $display("FAIL restart_count: got %h expected 000001", disp_bcd); end
    endtask

    task automatic test_rollover_overflow();
        bit found;
        do_reset();
        press_btn(0, 3);
        step(24000);
        checks++; if (disp_bcd !== 24'h005999) begin fails++; $display("FAIL pre_minute: got %h expected 005999", disp_bcd); end
        step(2);
        checks++; if (disp_bcd !== 24'h010000) begin fails++; $display("FAIL minute_carry: got %h expected 010000", disp_bcd); end
        press_btn(0, 3);
        step(2);
        checks++; if (fsm_state !== S_PAUSE) begin fails++; $display("FAIL ovf_pause: got %0d expected 2", fsm_state); end
        // preload the count just below saturation while paused
        force dut.count_q = 24'h595998;
        step(1);
        release dut.count_q;
        step(1);
        checks++; if (disp_bcd !== 24'h595998) begin fails++; $display("FAIL preload: got %h expected 595998", disp_bcd); end
        press_btn(0, 3);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (overflow === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (found !== 1'b1) begin fails++; $display("FAIL ovf_timeout: got overflow %b expected 1 within 60 cycles", overflow); end
        checks++; if (disp_bcd !== 24'h595999 || running !== 1'b0 || fsm_state !== S_PAUSE) begin fails++; $display("FAIL saturate: got %h run %b state %0d expected 595999 0 2", disp_bcd, running, fsm_state); end
        press_btn(0, 3);
        step(2);
        checks++; if (running !== 1'b1 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_resume: got run %b ovf %b expected 1 1", running, overflow); end
        step(20);
        checks++; if (disp_bcd !== 24'h595999 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_hold: got %h ovf %b expected 595999 1", disp_bcd, overflow); end
        press_btn(0, 3);
        step(2);
        press_btn(2, 3);
        step(2);
        checks++; if (fsm_state !== S_IDLE || overflow !== 1'b0 || disp_bcd !== 24'h0) begin fails++; $display("FAIL ovf_clear: got state %0d ovf %b disp %h expected 0 0 000000", fsm_state, overflow, disp_bcd); end
    endtask

    initial begin
        test_reset();
        test_ignored_idle();
        test_start_count();
        test_lap();
        test_pause_clear();
        test_back_to_back();
        test_reset_mid_run();
        test_rollover_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
